// File: rtl/id_ex_stage_pkg.sv
// Shared CPU constants: opcode/funct encodings, register aliases and the
// operand-select classes used by the ID/EX stage.
package id_ex_stage_pkg;

  localparam int OPCODE_WIDTH   = 6;
  localparam int FUNCCODE_WIDTH = 6;

  localparam logic [OPCODE_WIDTH-1:0] Op_Rtype = 6'h00;
  localparam logic [OPCODE_WIDTH-1:0] Op_Jal   = 6'h03;
  localparam logic [OPCODE_WIDTH-1:0] Op_Addi  = 6'h08;
  localparam logic [OPCODE_WIDTH-1:0] Op_Addiu = 6'h09;
  localparam logic [OPCODE_WIDTH-1:0] Op_Slti  = 6'h0A;
  localparam logic [OPCODE_WIDTH-1:0] Op_Sltiu = 6'h0B;
  localparam logic [OPCODE_WIDTH-1:0] Op_Andi  = 6'h0C;
  localparam logic [OPCODE_WIDTH-1:0] Op_Ori   = 6'h0D;
  localparam logic [OPCODE_WIDTH-1:0] Op_Xori  = 6'h0E;
  localparam logic [OPCODE_WIDTH-1:0] Op_Lui   = 6'h0F;
  localparam logic [OPCODE_WIDTH-1:0] Op_Lb    = 6'h20;
  localparam logic [OPCODE_WIDTH-1:0] Op_Lh    = 6'h21;
  localparam logic [OPCODE_WIDTH-1:0] Op_Lw    = 6'h23;
  localparam logic [OPCODE_WIDTH-1:0] Op_Lbu   = 6'h24;
  localparam logic [OPCODE_WIDTH-1:0] Op_Lhu   = 6'h25;
  localparam logic [OPCODE_WIDTH-1:0] Op_Sb    = 6'h28;
  localparam logic [OPCODE_WIDTH-1:0] Op_Sh    = 6'h29;
  localparam logic [OPCODE_WIDTH-1:0] Op_Sw    = 6'h2B;

  localparam logic [FUNCCODE_WIDTH-1:0] Func_Jr = 6'h08;

  localparam int Reg_Ra = 31;

  // How ALU operands A/B are formed from the captured instruction.
  typedef enum logic [1:0] {
    SEL_RR  = 2'd0,
    SEL_RI  = 2'd1,
    SEL_LUI = 2'd2,
    SEL_JAL = 2'd3
  } opnd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux32.sv
// Per-operand forwarding mux: EX/MEM beats MEM/WB beats the captured
// register-file data; register 0 is never forwarded.
module fwd_mux32 #(
  parameter int DP_WIDTH   = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic [DP_WIDTH-1:0]   src_data,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_dst_addr,
  input  logic [DP_WIDTH-1:0]   exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_dst_addr,
  input  logic [DP_WIDTH-1:0]   memwb_wdata,
  output logic [DP_WIDTH-1:0]   operand
);

  always_comb begin
    operand = src_data;
    if (src_addr != '0) begin
      if (exmem_reg_write && (exmem_dst_addr == src_addr)) begin
        operand = exmem_result;
      end else if (memwb_reg_write && (memwb_dst_addr == src_addr)) begin
        operand = memwb_wdata;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes and extends at capture, forwards and
// selects ALU operands combinationally, and inserts load-use bubbles.
module id_ex_stage #(
  parameter int DP_WIDTH   = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [5:0]            id_op_code,
  input  logic [5:0]            id_func_code,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic [DP_WIDTH-1:0]   id_rs_data,
  input  logic [DP_WIDTH-1:0]   id_rt_data,
  input  logic [15:0]           id_imm16,
  input  logic [4:0]            id_shamt,
  input  logic [DP_WIDTH-1:0]   id_pc_plus4,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_dst_addr,
  input  logic [DP_WIDTH-1:0]   exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_dst_addr,
  input  logic [DP_WIDTH-1:0]   memwb_wdata,
  output logic                  ex_valid,
  output logic [5:0]            ex_op_code,
  output logic [5:0]            ex_func_code,
  output logic [DP_WIDTH-1:0]   ex_alu_a,
  output logic [DP_WIDTH-1:0]   ex_alu_b,
  output logic [4:0]            ex_shamt,
  output logic [DP_WIDTH-1:0]   ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_dst_addr,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  load_use_stall
);

  import id_ex_stage_pkg::*;

  typedef struct packed {
    logic                  valid;
    logic [5:0]            op;
    logic [5:0]            func;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] dst;
    logic [DP_WIDTH-1:0]   rs_data;
    logic [DP_WIDTH-1:0]   rt_data;
    logic [DP_WIDTH-1:0]   imm;
    logic [DP_WIDTH-1:0]   pc_plus4;
    logic [4:0]            shamt;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    opnd_sel_e             sel;
  } ex_reg_t;

  ex_reg_t             dec;
  ex_reg_t             ex_d;
  ex_reg_t             ex_q;
  logic [DP_WIDTH-1:0] fwd_rs;
  logic [DP_WIDTH-1:0] fwd_rt;
  logic [DP_WIDTH-1:0] imm_sext;
  logic [DP_WIDTH-1:0] imm_zext;
  logic [DP_WIDTH-1:0] imm_lui;

  assign imm_sext = {{(DP_WIDTH-16){id_imm16[15]}}, id_imm16};
  assign imm_zext = {{(DP_WIDTH-16){1'b0}}, id_imm16};
  assign imm_lui  = {id_imm16, {(DP_WIDTH-16){1'b0}}};

  always_comb begin
    dec           = '0;
    dec.valid     = 1'b1;
    dec.op        = id_op_code;
    dec.func      = id_func_code;
    dec.rs        = id_rs_addr;
    dec.rt        = id_rt_addr;
    dec.rs_data   = id_rs_data;
    dec.rt_data   = id_rt_data;
    dec.pc_plus4  = id_pc_plus4;
    dec.shamt     = id_shamt;
    dec.imm       = imm_sext;
    dec.sel       = SEL_RR;
    case (id_op_code)
      Op_Rtype: begin
        dec.dst       = id_rd_addr;
        dec.reg_write = (id_func_code != Func_Jr);
      end
      Op_Addi, Op_Addiu, Op_Slti, Op_Sltiu: begin
        dec.dst       = id_rt_addr;
        dec.reg_write = 1'b1;
        dec.sel       = SEL_RI;
      end
      Op_Andi, Op_Ori, Op_Xori: begin
        dec.dst       = id_rt_addr;
        dec.reg_write = 1'b1;
        dec.imm       = imm_zext;
        dec.sel       = SEL_RI;
      end
      Op_Lui: begin
        dec.dst       = id_rt_addr;
        dec.reg_write = 1'b1;
        dec.imm       = imm_lui;
        dec.sel       = SEL_LUI;
      end
      Op_Lb, Op_Lh, Op_Lw, Op_Lbu, Op_Lhu: begin
        dec.dst       = id_rt_addr;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.sel       = SEL_RI;
      end
      Op_Sb, Op_Sh, Op_Sw: begin
        dec.mem_write = 1'b1;
        dec.sel       = SEL_RI;
      end
      Op_Jal: begin
        dec.dst       = REG_ADDR_W'(Reg_Ra);
        dec.reg_write = 1'b1;
        dec.sel       = SEL_JAL;
      end
      // Branches and jumps without a link write nothing; A/B carry rs/rt.
      default: ;
    endcase
  end

  assign load_use_stall = ex_q.valid && ex_q.mem_read && (ex_q.dst != '0) && id_valid &&
                          ((ex_q.dst == id_rs_addr) || (ex_q.dst == id_rt_addr));

  // Flush outranks hold so a redirect always squashes; a bubble is all-zero.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (!hold) begin
      if (load_use_stall || !id_valid) begin
        ex_d = '0;
      end else begin
        ex_d = dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_mux32 #(.DP_WIDTH(DP_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .src_addr        (ex_q.rs),
    .src_data        (ex_q.rs_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_dst_addr  (exmem_dst_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_dst_addr  (memwb_dst_addr),
    .memwb_wdata     (memwb_wdata),
    .operand         (fwd_rs)
  );

  fwd_mux32 #(.DP_WIDTH(DP_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .src_addr        (ex_q.rt),
    .src_data        (ex_q.rt_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_dst_addr  (exmem_dst_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_dst_addr  (memwb_dst_addr),
    .memwb_wdata     (memwb_wdata),
    .operand         (fwd_rt)
  );

  always_comb begin
    ex_alu_a = fwd_rs;
    ex_alu_b = fwd_rt;
    case (ex_q.sel)
      SEL_RI: begin
        ex_alu_b = ex_q.imm;
      end
      SEL_LUI: begin
        ex_alu_a = '0;
        ex_alu_b = ex_q.imm;
      end
      SEL_JAL: begin
        ex_alu_a = ex_q.pc_plus4;
        ex_alu_b = DP_WIDTH'(4);
      end
      default: ;
    endcase
  end

  assign ex_valid      = ex_q.valid;
  assign ex_op_code    = ex_q.op;
  assign ex_func_code  = ex_q.func;
  assign ex_shamt      = ex_q.shamt;
  assign ex_store_data = fwd_rt;
  assign ex_dst_addr   = ex_q.dst;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written hazard/hold/flush
// sequences, and randomized traffic against an instruction-level model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic [5:0]  id_op_code = '0;
  logic [5:0]  id_func_code = '0;
  logic [4:0]  id_rs_addr = '0, id_rt_addr = '0, id_rd_addr = '0;
  logic [31:0] id_rs_data = '0, id_rt_data = '0;
  logic [15:0] id_imm16 = '0;
  logic [4:0]  id_shamt = '0;
  logic [31:0] id_pc_plus4 = '0;
  logic        exmem_reg_write = 1'b0;
  logic [4:0]  exmem_dst_addr = '0;
  logic [31:0] exmem_result = '0;
  logic        memwb_reg_write = 1'b0;
  logic [4:0]  memwb_dst_addr = '0;
  logic [31:0] memwb_wdata = '0;

  logic        ex_valid;
  logic [5:0]  ex_op_code, ex_func_code;
  logic [31:0] ex_alu_a, ex_alu_b;
  logic [4:0]  ex_shamt;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dst_addr;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        load_use_stall;

  always #5 clk = ~clk;

  id_ex_stage #(.DP_WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_op_code(id_op_code), .id_func_code(id_func_code),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm16(id_imm16),
    .id_shamt(id_shamt), .id_pc_plus4(id_pc_plus4),
    .exmem_reg_write(exmem_reg_write), .exmem_dst_addr(exmem_dst_addr),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
    .memwb_dst_addr(memwb_dst_addr), .memwb_wdata(memwb_wdata),
    .ex_valid(ex_valid), .ex_op_code(ex_op_code), .ex_func_code(ex_func_code),
    .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_shamt(ex_shamt),
    .ex_store_data(ex_store_data), .ex_dst_addr(ex_dst_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .load_use_stall(load_use_stall)
  );

  typedef struct packed {
    logic        valid;
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] rs_d, rt_d, pc4;
    logic [15:0] imm;
  } instr_t;

  typedef struct packed {
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] rsd, rtd, pc;
    logic [15:0] imm;
    logic        exw;
    logic [4:0]  exd;
    logic [31:0] exr;
    logic        mww;
    logic [4:0]  mwd;
    logic [31:0] mwr;
    logic [31:0] ea, eb, es;
    logic [4:0]  ed;
    logic        erw, emr, emw;
  } vec_t;

  instr_t m = '0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_load(input logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction
  function automatic bit is_store(input logic [5:0] op);
    return op inside {6'h28, 6'h29, 6'h2B};
  endfunction
  function automatic bit is_sext_alu(input logic [5:0] op);
    return op inside {6'h08, 6'h09, 6'h0A, 6'h0B};
  endfunction
  function automatic bit is_zext_alu(input logic [5:0] op);
    return op inside {6'h0C, 6'h0D, 6'h0E};
  endfunction

  function automatic logic [4:0] dst_of(input instr_t x);
    if (!x.valid) return 5'd0;
    if (x.op == 6'h00) return x.rd;
    if (is_load(x.op) || is_sext_alu(x.op) || is_zext_alu(x.op) || x.op == 6'h0F) return x.rt;
    if (x.op == 6'h03) return 5'd31;
    return 5'd0;
  endfunction

  function automatic logic rw_of(input instr_t x);
    if (!x.valid) return 1'b0;
    if (x.op == 6'h00) return x.func != 6'h08;
    return is_load(x.op) || is_sext_alu(x.op) || is_zext_alu(x.op) || x.op == 6'h0F || x.op == 6'h03;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] d);
    if (src == 0) return d;
    if (exmem_reg_write && exmem_dst_addr == src) return exmem_result;
    if (memwb_reg_write && memwb_dst_addr == src) return memwb_wdata;
    return d;
  endfunction

  function automatic logic exp_stall();
    logic [4:0] d;
    d = dst_of(m);
    return m.valid && is_load(m.op) && d != 0 && id_valid && (d == id_rs_addr || d == id_rt_addr);
  endfunction

  task automatic model_check();
    logic [31:0] ea, eb;
    chk("load_use_stall", load_use_stall, exp_stall());
    ea = fwd(m.rs, m.rs_d);
    eb = fwd(m.rt, m.rt_d);
    if (m.op == 6'h0F) begin
      ea = 0;
      eb = {m.imm, 16'h0};
    end else if (m.op == 6'h03) begin
      ea = m.pc4;
      eb = 32'd4;
    end else if (is_sext_alu(m.op) || is_load(m.op) || is_store(m.op)) begin
      eb = 32'($signed(m.imm));
    end else if (is_zext_alu(m.op)) begin
      eb = 32'(m.imm);
    end
    if (!m.valid) begin
      ea = 0;
      eb = 0;
    end
    chk("ex_valid", ex_valid, m.valid);
    chk("ex_op_code", ex_op_code, m.valid ? m.op : 6'h0);
    chk("ex_func_code", ex_func_code, m.valid ? m.func : 6'h0);
    chk("ex_shamt", ex_shamt, m.valid ? m.shamt : 5'h0);
    chk("ex_alu_a", ex_alu_a, ea);
    chk("ex_alu_b", ex_alu_b, eb);
    chk("ex_store_data", ex_store_data, m.valid ? fwd(m.rt, m.rt_d) : 32'h0);
    chk("ex_dst_addr", ex_dst_addr, dst_of(m));
    chk("ex_reg_write", ex_reg_write, rw_of(m));
    chk("ex_mem_read", ex_mem_read, m.valid && is_load(m.op));
    chk("ex_mem_write", ex_mem_write, m.valid && is_store(m.op));
  endtask

  task automatic model_edge();
    logic st;
    st = exp_stall();
    if (rst || flush) m = '0;
    else if (hold) m = m;
    else if (st || !id_valid) m = '0;
    else m = '{1'b1, id_op_code, id_func_code, id_rs_addr, id_rt_addr, id_rd_addr,
               id_shamt, id_rs_data, id_rt_data, id_pc_plus4, id_imm16};
  endtask

  // Inputs change only at the falling edge; each tick crosses one rising edge
  // and checks the model at the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic drive_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [4:0] sh, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] pc, input logic [15:0] imm);
    id_valid = v; id_op_code = op; id_func_code = fn;
    id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd; id_shamt = sh;
    id_rs_data = rsd; id_rt_data = rtd; id_pc_plus4 = pc; id_imm16 = imm;
  endtask

  task automatic drive_fwd(input logic exw, input logic [4:0] exd, input logic [31:0] exr,
                           input logic mww, input logic [4:0] mwd, input logic [31:0] mwr);
    exmem_reg_write = exw; exmem_dst_addr = exd; exmem_result = exr;
    memwb_reg_write = mww; memwb_dst_addr = mwd; memwb_wdata = mwr;
  endtask

  function automatic vec_t mk(
    input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [4:0] sh, input logic [31:0] rsd, input logic [31:0] rtd,
    input logic [31:0] pc, input logic [15:0] imm,
    input logic exw, input logic [4:0] exd, input logic [31:0] exr,
    input logic mww, input logic [4:0] mwd, input logic [31:0] mwr,
    input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] es, input logic [4:0] ed,
    input logic erw, input logic emr, input logic emw);
    return '{op, fn, rs, rt, rd, sh, rsd, rtd, pc, imm, exw, exd, exr, mww, mwd, mwr,
             ea, eb, es, ed, erw, emr, emw};
  endfunction

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 17))
      0, 1, 2: return 6'h00;
      3:  return 6'h03;
      4:  return 6'h04;
      5:  return 6'h08;
      6:  return 6'h09;
      7:  return 6'h0A;
      8:  return 6'h0C;
      9:  return 6'h0D;
      10: return 6'h0F;
      11: return 6'h20;
      12, 13: return 6'h23;
      14: return 6'h25;
      15: return 6'h28;
      16: return 6'h2B;
      default: return 6'h0E;
    endcase
  endfunction

  vec_t tbl [13];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(6'h08, 6'h00, 9, 8, 0, 0, 32'h5, 32'h77, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0,
                 32'h5, 32'hFFFF_FFFF, 32'h77, 8, 1, 0, 0);
    tbl[1]  = mk(6'h0D, 6'h00, 2, 3, 0, 0, 32'h10, 32'h0, 0, 16'h8000, 0, 0, 0, 0, 0, 0,
                 32'h10, 32'h0000_8000, 32'h0, 3, 1, 0, 0);
    tbl[2]  = mk(6'h00, 6'h20, 1, 2, 3, 0, 32'h111, 32'h222, 0, 0, 1, 1, 32'hAAAA, 1, 2, 32'hCCCC,
                 32'hAAAA, 32'hCCCC, 32'hCCCC, 3, 1, 0, 0);
    tbl[3]  = mk(6'h00, 6'h20, 1, 2, 3, 0, 32'h111, 32'h222, 0, 0, 1, 1, 32'hAAAA, 1, 1, 32'hBBBB,
                 32'hAAAA, 32'h222, 32'h222, 3, 1, 0, 0);
    tbl[4]  = mk(6'h00, 6'h20, 1, 2, 3, 0, 32'h111, 32'h222, 0, 0, 0, 1, 32'hAAAA, 1, 1, 32'hBBBB,
                 32'hBBBB, 32'h222, 32'h222, 3, 1, 0, 0);
    tbl[5]  = mk(6'h00, 6'h20, 0, 0, 3, 0, 32'h111, 32'h222, 0, 0, 1, 0, 32'hAAAA, 1, 0, 32'hCCCC,
                 32'h111, 32'h222, 32'h222, 3, 1, 0, 0);
    tbl[6]  = mk(6'h0F, 6'h00, 0, 7, 0, 0, 32'h55, 32'h66, 0, 16'h1234, 0, 0, 0, 0, 0, 0,
                 32'h0, 32'h1234_0000, 32'h66, 7, 1, 0, 0);
    tbl[7]  = mk(6'h03, 6'h00, 0, 0, 0, 0, 32'h0, 32'h0, 32'h400, 0, 0, 0, 0, 0, 0, 0,
                 32'h400, 32'h4, 32'h0, 31, 1, 0, 0);
    tbl[8]  = mk(6'h2B, 6'h00, 5, 6, 0, 0, 32'h1000, 32'h99, 0, 16'hFFF8, 0, 0, 0, 1, 6, 32'hDEAD,
                 32'h1000, 32'hFFFF_FFF8, 32'hDEAD, 0, 0, 0, 1);
    tbl[9]  = mk(6'h23, 6'h00, 10, 4, 0, 0, 32'h2000, 32'h3, 0, 16'h0004, 0, 0, 0, 0, 0, 0,
                 32'h2000, 32'h4, 32'h3, 4, 1, 1, 0);
    tbl[10] = mk(6'h00, 6'h08, 31, 0, 0, 0, 32'h500, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0,
                 32'h500, 32'h0, 32'h0, 0, 0, 0, 0);
    tbl[11] = mk(6'h00, 6'h00, 0, 3, 2, 4, 32'h0, 32'hF, 0, 0, 0, 0, 0, 0, 0, 0,
                 32'h0, 32'hF, 32'hF, 2, 1, 0, 0);
    tbl[12] = mk(6'h0C, 6'h00, 1, 1, 0, 0, 32'h1234_5678, 32'h0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0,
                 32'h1234_5678, 32'h0000_FFFF, 32'h0, 1, 1, 0, 0);

    // Reset state
    @(negedge clk);
    tick();
    tick();
    chk("reset ex_valid", ex_valid, 1'b0);
    chk("reset ex_alu_a", ex_alu_a, 32'h0);
    chk("reset ex_alu_b", ex_alu_b, 32'h0);
    chk("reset stall", load_use_stall, 1'b0);
    rst = 1'b0;

    // Directed table, a bubble between entries
    for (int i = 0; i < 13; i++) begin
      drive_fwd(tbl[i].exw, tbl[i].exd, tbl[i].exr, tbl[i].mww, tbl[i].mwd, tbl[i].mwr);
      drive_id(1'b1, tbl[i].op, tbl[i].func, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].sh,
               tbl[i].rsd, tbl[i].rtd, tbl[i].pc, tbl[i].imm);
      tick();
      chk($sformatf("vec%0d alu_a", i), ex_alu_a, tbl[i].ea);
      chk($sformatf("vec%0d alu_b", i), ex_alu_b, tbl[i].eb);
      chk($sformatf("vec%0d store", i), ex_store_data, tbl[i].es);
      chk($sformatf("vec%0d dst", i), ex_dst_addr, tbl[i].ed);
      chk($sformatf("vec%0d ctl", i), {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write},
          {1'b1, tbl[i].erw, tbl[i].emr, tbl[i].emw});
      drive_fwd(0, 0, 0, 0, 0, 0);
      id_valid = 1'b0;
      tick();
    end

    // Load-use: lw $4 in EX, add $5,$4,$6 in ID
    drive_id(1'b1, 6'h23, 6'h00, 10, 4, 0, 0, 32'h2000, 32'h0, 0, 16'h0008);
    tick();
    drive_id(1'b1, 6'h00, 6'h20, 4, 6, 5, 0, 32'h40, 32'h60, 0, 0);
    #1;
    chk("lu stall asserted", load_use_stall, 1'b1);
    tick();
    chk("lu bubble valid", ex_valid, 1'b0);
    chk("lu bubble stall clear", load_use_stall, 1'b0);
    tick();
    chk("lu recapture valid", ex_valid, 1'b1);
    chk("lu recapture dst", ex_dst_addr, 5'd5);

    // Stall under hold: hold keeps the load in EX
    drive_id(1'b1, 6'h23, 6'h00, 10, 4, 0, 0, 32'h2000, 32'h0, 0, 16'h0008);
    tick();
    drive_id(1'b1, 6'h00, 6'h20, 6, 4, 5, 0, 32'h40, 32'h60, 0, 0);
    hold = 1'b1;
    #1;
    chk("hold stall asserted", load_use_stall, 1'b1);
    tick();
    chk("hold keeps load", {ex_valid, ex_mem_read, 3'b0, ex_dst_addr}, {1'b1, 1'b1, 3'b0, 5'd4});

    // flush + hold with a valid ID instruction -> bubble
    flush = 1'b1;
    tick();
    chk("flush+hold bubble", ex_valid, 1'b0);
    flush = 1'b0;
    hold = 1'b0;

    // hold for 3 cycles with changing ID inputs
    drive_id(1'b1, 6'h08, 6'h00, 9, 8, 0, 0, 32'h5, 32'h77, 0, 16'hFFFF);
    tick();
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_id(1'b1, rand_op(), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), $urandom, $urandom, $urandom, 16'($urandom));
      tick();
      chk($sformatf("hold%0d alu_a", k), ex_alu_a, 32'h5);
      chk($sformatf("hold%0d alu_b", k), ex_alu_b, 32'hFFFF_FFFF);
      chk($sformatf("hold%0d dst", k), ex_dst_addr, 5'd8);
    end
    hold = 1'b0;

    // Randomized traffic against the model, with a mid-stream reset
    for (int i = 0; i < 600; i++) begin
      drive_id($urandom_range(0, 99) < 85, rand_op(),
               ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom), $urandom, $urandom, $urandom, 16'($urandom));
      drive_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      hold  = $urandom_range(0, 99) < 20;
      flush = $urandom_range(0, 99) < 8;
      rst   = (i == 300 || i == 301);
      tick();
      if (i == 301) begin
        chk("midreset ex_valid", ex_valid, 1'b0);
        chk("midreset ctl", {ex_reg_write, ex_mem_read, ex_mem_write}, 3'b000);
        chk("midreset alu_a", ex_alu_a, 32'h0);
        chk("midreset alu_b", ex_alu_b, 32'h0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of ALU_Unit: registers decoded instructions from ID and extends immediates.
- Applies EX/MEM and MEM/WB forwarding, then drives ALU operands A/B/Shamt plus op/func codes for ALU_Controller.
- Detects load-use hazards and inserts bubbles; honours global hold and branch flush.

Parameters:
DP_WIDTH, 32, datapath width (cpu_para.v value)
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
hold  in  1  freeze whole stage (memory wait)
flush  in  1  squash instruction entering EX (branch/jump redirect)
id_valid  in  1  ID holds a real instruction
id_op_code  in  6  opcode
id_func_code  in  6  funct
id_rs_addr, id_rt_addr, id_rd_addr  in  5 each  register indices
id_rs_data, id_rt_data  in  32 each  register-file read data
id_imm16  in  16  immediate
id_shamt  in  5  shift amount
id_pc_plus4  in  32  PC+4 of instruction
exmem_reg_write  in  1  EX/MEM instruction writes a register
exmem_dst_addr  in  5  EX/MEM destination
exmem_result  in  32  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB instruction writes a register
memwb_dst_addr  in  5  MEM/WB destination
memwb_wdata  in  32  MEM/WB write-back data
ex_valid  out  1  EX slot holds a real instruction
ex_op_code, ex_func_code  out  6 each  to ALU_Controller
ex_alu_a, ex_alu_b  out  32 each  to ALU_Unit A/B
ex_shamt  out  5  to ALU_Unit Shamt
ex_store_data  out  32  forwarded rt value for sb/sh/sw
ex_dst_addr  out  5  write-back destination
ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  control bits
load_use_stall  out  1  upstream must hold IF/ID this cycle

Behaviour:
- Reset: all registered fields 0. ex_valid=0, all control bits 0, ex_alu_a/ex_alu_b=0, load_use_stall=0.
- Latency: 1 cycle. ID fields captured at a rising edge appear on ex_* after that edge.
- Per-edge priority:
  - rst: clear everything.
  - flush: load bubble.
  - hold: keep all registered state.
  - load_use_stall: load bubble.
  - Otherwise load ID fields.
- Bubble: ex_valid=0, reg_write/mem_read/mem_write=0, dst=0. Data fields don't-care but driven 0.
- An instruction with id_valid=0 is loaded as a bubble.
- load_use_stall, combinational: ex_valid & ex_mem_read & ex_dst_addr!=0 & id_valid & (ex_dst_addr==id_rs_addr | ex_dst_addr==id_rt_addr). It is asserted even when hold=1; hold still wins at the edge.
- Decode at capture:
  - R-type: dst=rd, reg_write=1 except jr (func 0x08). jr gets reg_write=0.
  - I-type ALU ops and loads: dst=rt.
  - jal: dst=31.
  - Loads set mem_read. Stores set mem_write and reg_write=0.
- Immediate extension:
  - Sign-extend: addi, addiu, slti, sltiu, all loads, all stores.
  - Zero-extend: andi, ori, xori.
  - lui: imm16<<16.
- Forwarding (combinational on registered rs/rt, per operand), highest priority first:
  - exmem_reg_write & exmem_dst_addr==src & src!=0 → exmem_result.
  - memwb_reg_write & memwb_dst_addr==src & src!=0 → memwb_wdata.
  - Otherwise the registered read data.
  - Register 0 always reads as captured (never forwarded).
- Operand select:
  - R-type: A=fwd rs, B=fwd rt.
  - sll/srl: Shamt=registered shamt.
  - I-type: A=fwd rs, B=ext imm.
  - lui: A=0, B=imm<<16.
  - jal: A=pc_plus4, B=4.
  - ex_store_data is always fwd rt.
- Outputs during hold are unchanged except through forwarding inputs. Downstream stages are also held, so those inputs are stable.

Decomposition:
- Op_*, Func_*, DP_WIDTH, OPCODE_WIDTH and FUNCCODE_WIDTH live in the shared cpu_para.v.
- Add new constants there: Func_Jr and Reg_Ra=31.
- One sub-module: fwd_mux32 (src addr, captured data, two forwarding sources → operand), instantiated twice (rs, rt).

Test Plan:
- rst=1 for 2 cycles mid-stream → all outputs 0, ex_valid=0 at next edge.
- addi $8,$9,-1 with rs_data=5 → next cycle: ex_alu_a=5, ex_alu_b=0xFFFFFFFF, dst=8, reg_write=1. ori with imm 0x8000 → ex_alu_b=0x00008000.
- add $3,$1,$2 with exmem (wr=1, dst=1, 0xAAAA) and memwb (wr=1, dst=1, 0xBBBB, plus dst=2, 0xCCCC) → ex_alu_a=0xAAAA, ex_alu_b=0xCCCC. Same with dst=0 → original read data.
- lw $4 in EX, ID add $5,$4,$6 → load_use_stall=1. Next cycle ex_valid=0 and the add is re-captured one cycle later.
- flush=1 and hold=1 simultaneously with valid ID → bubble loaded. hold alone for 3 cycles → ex_* unchanged.
- lui $7,0x1234 → A=0, B=0x12340000. jal with pc_plus4=0x400 → A=0x400, B=4, dst=31.
